// File: rtl/alu_pkg.sv
// Shared ALU definitions: control width and RV32I operation encoding.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_AND  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_XOR  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The last_grant pointer moves only when the
// owner of the current grant completes a transfer (advance).
module rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= RR_INIT;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; the winning operation's
// result is captured in a one-deep response register with its source and tag.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int RR_INIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [31:0]           req0_op_a,
  input  logic [31:0]           req0_op_b,
  input  logic [ALU_CTRL_W-1:0] req0_ctrl,
  input  logic [TAG_W-1:0]      req0_tag,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [31:0]           req1_op_a,
  input  logic [31:0]           req1_op_b,
  input  logic [ALU_CTRL_W-1:0] req1_ctrl,
  input  logic [TAG_W-1:0]      req1_tag,
  output logic [31:0]           alu_operand_a,
  output logic [31:0]           alu_operand_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_src,
  output logic [TAG_W-1:0]      rsp_tag
);

  localparam bit RR_INIT_B = (RR_INIT != 0);

  logic [1:0] grant;
  logic       can_issue;
  logic       fire0;
  logic       fire1;
  logic       fire;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. Valid never waits on ready; once raised, the payload stays
  // stable until ready is seen. The response side follows the same rule.
  assign can_issue  = !rsp_valid || rsp_ready;
  assign req0_ready = !rst && can_issue && grant[0];
  assign req1_ready = !rst && can_issue && grant[1];
  assign fire0      = req0_valid && req0_ready;
  assign fire1      = req1_valid && req1_ready;
  assign fire       = fire0 || fire1;

  rr_arb2 #(
    .RR_INIT (RR_INIT_B)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({req1_valid, req0_valid}),
    .advance (fire),
    .grant   (grant)
  );

  // The ALU sees the grant candidate even while the response slot is full,
  // which keeps ready out of the requester's valid path.
  always_comb begin
    alu_operand_a = 32'd0;
    alu_operand_b = 32'd0;
    alu_control   = ALU_ADD;
    if (grant[1]) begin
      alu_operand_a = req1_op_a;
      alu_operand_b = req1_op_b;
      alu_control   = req1_ctrl;
    end else if (grant[0]) begin
      alu_operand_a = req0_op_a;
      alu_operand_b = req0_op_b;
      alu_control   = req0_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp_src    <= 1'b0;
      rsp_tag    <= '0;
    end else if (fire) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero_flag;
      rsp_src    <= fire1;
      rsp_tag    <= fire1 ? req1_tag : req0_tag;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU closes the loop, the
// stimulus process queues expected responses and a monitor checks them.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int TAG_W = 4;
  localparam int EXP_W = 32 + 1 + 1 + TAG_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [31:0] req0_op_a = '0, req0_op_b = '0, req1_op_a = '0, req1_op_b = '0;
  logic [3:0] req0_ctrl = '0, req1_ctrl = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic [31:0] alu_operand_a, alu_operand_b, alu_result;
  logic [3:0] alu_control;
  logic alu_zero_flag;
  logic rsp_valid, rsp_zero, rsp_src;
  logic rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  logic [31:0] e0_res = '0, e1_res = '0;
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(TAG_W), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op_a(req0_op_a),
    .req0_op_b(req0_op_b), .req0_ctrl(req0_ctrl), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op_a(req1_op_a),
    .req1_op_b(req1_op_b), .req1_ctrl(req1_ctrl), .req1_tag(req1_tag),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_control(alu_control), .alu_result(alu_result),
    .alu_zero_flag(alu_zero_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_src(rsp_src), .rsp_tag(rsp_tag)
  );

  // Behavioural shared ALU.
  always_comb begin
    case (alu_control)
      ALU_ADD:  alu_result = alu_operand_a + alu_operand_b;
      ALU_SUB:  alu_result = alu_operand_a - alu_operand_b;
      ALU_SLL:  alu_result = alu_operand_a << alu_operand_b[4:0];
      ALU_SRL:  alu_result = alu_operand_a >> alu_operand_b[4:0];
      ALU_SRA:  alu_result = $unsigned($signed(alu_operand_a) >>> alu_operand_b[4:0]);
      ALU_SLT:  alu_result = {31'd0, $signed(alu_operand_a) < $signed(alu_operand_b)};
      ALU_SLTU: alu_result = {31'd0, alu_operand_a < alu_operand_b};
      ALU_AND:  alu_result = alu_operand_a & alu_operand_b;
      ALU_OR:   alu_result = alu_operand_a | alu_operand_b;
      ALU_XOR:  alu_result = alu_operand_a ^ alu_operand_b;
      default:  alu_result = 32'd0;
    endcase
    alu_zero_flag = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req0(input logic v, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] t, input logic [31:0] e);
    req0_valid = v; req0_ctrl = c; req0_op_a = a; req0_op_b = b; req0_tag = t; e0_res = e;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] t, input logic [31:0] e);
    req1_valid = v; req1_ctrl = c; req1_op_a = a; req1_op_b = b; req1_tag = t; e1_res = e;
  endtask

  // Called at the negedge: records the handshakes about to happen, then
  // advances to just after the rising edge.
  task automatic commit();
    if (req0_valid && req0_ready)
      exp_q.push_back({e0_res, (e0_res == 32'd0), 1'b0, req0_tag});
    if (req1_valid && req1_ready)
      exp_q.push_back({e1_res, (e1_res == 32'd0), 1'b1, req1_tag});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      commit();
    end
  endtask

  // Monitor: every response that is consumed is checked against the queue.
  initial begin
    logic [EXP_W-1:0] exp;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got result=0x%0h src=%0d tag=%0d, expected no response",
                   rsp_result, rsp_src, rsp_tag);
        end else begin
          exp = exp_q.pop_front();
          if ({rsp_result, rsp_zero, rsp_src, rsp_tag} !== exp)
            begin
              n_fail++;
              $display("FAIL rsp: got result=0x%0h zero=%0d src=%0d tag=%0d, expected result=0x%0h zero=%0d src=%0d tag=%0d",
                       rsp_result, rsp_zero, rsp_src, rsp_tag,
                       exp[EXP_W-1 -: 32], exp[TAG_W+1], exp[TAG_W], exp[TAG_W-1:0]);
            end
        end
      end
    end
  end

  initial begin
    // Reset with both requesters asking: nothing may be accepted.
    set_req0(1'b1, ALU_ADD, 32'd1, 32'd2, 4'd1, 32'd3);
    set_req1(1'b1, ALU_ADD, 32'd3, 32'd4, 4'd2, 32'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_ready0", {31'd0, req0_ready}, 32'd0);
      chk("reset_ready1", {31'd0, req1_ready}, 32'd0);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      commit();
    end
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    chk("reset_rsp_src", {31'd0, rsp_src}, 32'd0);
    chk("reset_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    rst = 1'b0;
    set_req0(1'b0, ALU_ADD, 32'd0, 32'd0, 4'd0, 32'd0);
    set_req1(1'b0, ALU_ADD, 32'd0, 32'd0, 4'd0, 32'd0);
    rsp_ready = 1'b1;
    idle(1);

    // Single op from requester 0.
    set_req0(1'b1, ALU_ADD, 32'd5, 32'd7, 4'd3, 32'd12);
    @(negedge clk);
    chk("single_ready0", {31'd0, req0_ready}, 32'd1);
    chk("single_ready1", {31'd0, req1_ready}, 32'd0);
    commit();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    commit();

    // Contention: grants alternate 1,0,1,0.
    set_req0(1'b1, ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 4'd1, 32'h0000_FF00);
    set_req1(1'b1, ALU_SUB, 32'd9, 32'd9, 4'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_ready1", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      commit();
    end

    // Backpressure: response held, no new issue, then drain and issue together.
    set_req0(1'b0, ALU_ADD, 32'd0, 32'd0, 4'd0, 32'd0);
    set_req1(1'b1, ALU_AND, 32'h0000_00FF, 32'h0000_000F, 4'd5, 32'h0000_000F);
    @(negedge clk);
    commit();
    rsp_ready = 1'b0;
    set_req1(1'b0, ALU_ADD, 32'd0, 32'd0, 4'd0, 32'd0);
    set_req0(1'b1, ALU_OR, 32'h0000_00A0, 32'h0000_0005, 4'd6, 32'h0000_00A5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_result", rsp_result, 32'h0000_000F);
      chk("bp_rsp_tag", {28'd0, rsp_tag}, 32'd5);
      chk("bp_rsp_src", {31'd0, rsp_src}, 32'd1);
      commit();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready0", {31'd0, req0_ready}, 32'd1);
    commit();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("bp_replaced_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_replaced_src", {31'd0, rsp_src}, 32'd0);
    commit();
    @(negedge clk);
    chk("bp_drained_valid", {31'd0, rsp_valid}, 32'd0);
    commit();

    // Streaming from requester 0: no bubble between responses.
    set_req0(1'b1, ALU_SLL, 32'd1, 32'd31, 4'd7, 32'h8000_0000);
    @(negedge clk);
    chk("stream_ready0_a", {31'd0, req0_ready}, 32'd1);
    commit();
    set_req0(1'b1, ALU_SRA, 32'h8000_0000, 32'd4, 4'd8, 32'hF800_0000);
    @(negedge clk);
    chk("stream_ready0_b", {31'd0, req0_ready}, 32'd1);
    chk("stream_rsp_valid_a", {31'd0, rsp_valid}, 32'd1);
    commit();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("stream_rsp_valid_b", {31'd0, rsp_valid}, 32'd1);
    commit();

    // Comparisons and undefined control codes streamed from requester 1.
    set_req1(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 4'd10, 32'd1);
    idle(1);
    set_req1(1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 4'd11, 32'd0);
    idle(1);
    set_req1(1'b1, ALU_SRL, 32'h8000_0000, 32'd31, 4'd12, 32'd1);
    idle(1);
    set_req1(1'b1, 4'hF, 32'd3, 32'd4, 4'd13, 32'd0);
    idle(1);
    req1_valid = 1'b0;
    idle(2);

    // Mid-op reset: pending response dropped, pointer back to RR_INIT.
    set_req1(1'b1, ALU_ADD, 32'd1, 32'd1, 4'd9, 32'd2);
    idle(1);
    rsp_ready = 1'b0;
    rst = 1'b1;
    set_req0(1'b1, ALU_ADD, 32'd2, 32'd2, 4'd4, 32'd4);
    @(negedge clk);
    chk("midrst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("midrst_ready1", {31'd0, req1_ready}, 32'd0);
    commit();
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_result", rsp_result, 32'd0);
    chk("midrst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    chk("midrst_rr_ready1", {31'd0, req1_ready}, 32'd1);
    chk("midrst_rr_ready0", {31'd0, req0_ready}, 32'd0);
    commit();
    set_req0(1'b0, ALU_ADD, 32'd0, 32'd0, 4'd0, 32'd0);
    set_req1(1'b0, ALU_ADD, 32'd0, 32'd0, 4'd0, 32'd0);
    idle(3);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
